// File: rtl/czonotope_loader_if.sv
// CZonotope: constrained zonotope container (n, ng, nc, c, G, A, b) shared by the set-operation blocks.
interface CZonotope #(
    parameter int NMAX       = 4,
    parameter int NGMAX      = 8,
    parameter int NCMAX      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int MAXD = NGMAX > NMAX ? (NGMAX > NCMAX ? NGMAX : NCMAX) : (NMAX > NCMAX ? NMAX : NCMAX);
    localparam int DW   = $clog2(MAXD + 1);
    logic [DW-1:0]         n;
    logic [DW-1:0]         ng;
    logic [DW-1:0]         nc;
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];
    modport wr (output n, ng, nc, c, G, A, b);
    modport rd (input n, ng, nc, c, G, A, b);
endinterface

// File: rtl/czonotope_loader.sv
// czonotope_loader: fills a CZonotope from a word-serial valid/ready stream
// (header n, ng, nc, then c, G row-major, A row-major, b).
module czonotope_loader #(
    parameter int NMAX       = 4,
    parameter int NGMAX      = 8,
    parameter int NCMAX      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    CZonotope.wr                  OUT,
    output logic                  busy_o,
    output logic                  loaded_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int MAXD = NGMAX > NMAX ? (NGMAX > NCMAX ? NGMAX : NCMAX) : (NMAX > NCMAX ? NMAX : NCMAX);
    localparam int DW   = $clog2(MAXD + 1);
    localparam int CI   = $clog2(NMAX);
    localparam int GI   = $clog2(NGMAX);
    localparam int AI   = $clog2(NCMAX);
    localparam logic [DW-1:0] N_MAX  = DW'(NMAX);
    localparam logic [DW-1:0] NG_MAX = DW'(NGMAX);
    localparam logic [DW-1:0] NC_MAX = DW'(NCMAX);

    typedef enum logic [3:0] {IDLE, HDR_N, HDR_NG, HDR_NC, LD_C, LD_G, LD_A, LD_B, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] i, j, hdr;
    logic          acc, last_n, last_c, last_g, bad;

    assign hdr       = s_data_i[DW-1:0];
    assign s_ready_o = !(state_q inside {IDLE, DONE});
    assign acc       = s_valid_i & s_ready_o;
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DONE;
    assign last_n    = i == OUT.n - 1'b1;
    assign last_c    = i == OUT.nc - 1'b1;
    assign last_g    = j == OUT.ng - 1'b1;
    // n and ng are already latched when the nc word arrives
    assign bad       = OUT.n == '0 || OUT.n > N_MAX || OUT.ng > NG_MAX || hdr > NC_MAX;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? HDR_N : IDLE;
            HDR_N:   state_d = acc ? HDR_NG : HDR_N;
            HDR_NG:  state_d = acc ? HDR_NC : HDR_NG;
            HDR_NC:  state_d = !acc ? HDR_NC : bad ? IDLE : LD_C;
            LD_C:    if (acc && last_n) state_d = OUT.ng != '0 ? LD_G : OUT.nc != '0 ? LD_B : DONE;
            LD_G:    if (acc && last_n && last_g) state_d = OUT.nc != '0 ? LD_A : DONE;
            LD_A:    if (acc && last_c && last_g) state_d = LD_B;
            LD_B:    if (acc && last_c) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            OUT.n    <= '0;
            OUT.ng   <= '0;
            OUT.nc   <= '0;
            i        <= '0;
            j        <= '0;
            loaded_o <= 1'b0;
            err_o    <= 1'b0;
            for (int r = 0; r < NMAX; r++) begin
                OUT.c[r] <= '0;
                for (int k = 0; k < NGMAX; k++) OUT.G[r][k] <= '0;
            end
            for (int r = 0; r < NCMAX; r++) begin
                OUT.b[r] <= '0;
                for (int k = 0; k < NGMAX; k++) OUT.A[r][k] <= '0;
            end
        end else begin
            err_o <= acc && state_q == HDR_NC && bad;
            if (state_q == IDLE && start_i) loaded_o <= 1'b0;
            else if (state_d == DONE)       loaded_o <= 1'b1;
            // counters restart on every state change, so each section begins at (0,0)
            if (state_d != state_q) begin
                i <= '0;
                j <= '0;
            end else if (acc && (state_q == LD_G || state_q == LD_A)) begin
                j <= last_g ? '0 : j + 1'b1;
                i <= last_g ? i + 1'b1 : i;
            end else if (acc) begin
                i <= i + 1'b1;
            end
            if (acc) begin
                case (state_q)
                    HDR_N:  OUT.n  <= hdr;
                    HDR_NG: OUT.ng <= hdr;
                    HDR_NC: begin
                        OUT.nc <= bad ? '0 : hdr;
                        if (bad) begin
                            OUT.n  <= '0;
                            OUT.ng <= '0;
                        end
                        for (int r = 0; r < NMAX; r++) begin
                            OUT.c[r] <= '0;
                            for (int k = 0; k < NGMAX; k++) OUT.G[r][k] <= '0;
                        end
                        for (int r = 0; r < NCMAX; r++) begin
                            OUT.b[r] <= '0;
                            for (int k = 0; k < NGMAX; k++) OUT.A[r][k] <= '0;
                        end
                    end
                    LD_C:    OUT.c[i[CI-1:0]] <= s_data_i;
                    LD_G:    OUT.G[i[CI-1:0]][j[GI-1:0]] <= s_data_i;
                    LD_A:    OUT.A[i[AI-1:0]][j[GI-1:0]] <= s_data_i;
                    LD_B:    OUT.b[i[AI-1:0]] <= s_data_i;
                    default: ;
                endcase
            end
        end
    end
endmodule
